// File: rtl/alu_interface.sv
// Serial front end for a combinational ALU: collects operand A, operand B and an
// op-code from a byte receiver, then returns the result byte and a flag byte.
module alu_interface #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP_CODE = 6
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_DATA-1:0]    i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  input  logic [NB_DATA-1:0]    i_alu_result,
  input  logic                  i_alu_zero,
  input  logic                  i_alu_carry,
  output logic [NB_DATA-1:0]    o_data_a,
  output logic [NB_DATA-1:0]    o_data_b,
  output logic [NB_OP_CODE-1:0] o_op_code,
  output logic [NB_DATA-1:0]    o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic [2:0]            o_state
);

  // Handshake: i_rx_done and i_tx_done are single-cycle strobes that only count
  // in the states waiting for them; o_tx_start is a single-cycle strobe and
  // o_tx_data is stable from that cycle until the next strobe.
  typedef enum logic [2:0] {
    GET_A    = 3'd0,
    GET_B    = 3'd1,
    GET_OP   = 3'd2,
    EXEC     = 3'd3,
    SEND_RES = 3'd4,
    WAIT_RES = 3'd5,
    SEND_FLG = 3'd6,
    WAIT_FLG = 3'd7
  } state_t;

  state_t             state;
  logic [NB_DATA-1:0] result_q;
  logic [1:0]         flags_q;   // {carry, zero}

  assign o_busy  = (state != GET_A);
  assign o_state = state;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= GET_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op_code  <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        GET_A: begin
          if (i_rx_done) begin
            o_data_a <= i_rx_data;
            state    <= GET_B;
          end
        end
        GET_B: begin
          if (i_rx_done) begin
            o_data_b <= i_rx_data;
            state    <= GET_OP;
          end
        end
        GET_OP: begin
          if (i_rx_done) begin
            o_op_code <= i_rx_data[NB_OP_CODE-1:0];
            state     <= EXEC;
          end
        end
        EXEC: begin
          // Operands and op-code have been stable for a full cycle here.
          result_q <= i_alu_result;
          flags_q  <= {i_alu_carry, i_alu_zero};
          state    <= SEND_RES;
        end
        SEND_RES: begin
          o_tx_data  <= result_q;
          o_tx_start <= 1'b1;
          state      <= WAIT_RES;
        end
        WAIT_RES: begin
          if (i_tx_done) state <= SEND_FLG;
        end
        SEND_FLG: begin
          o_tx_data  <= {{(NB_DATA-2){1'b0}}, flags_q};
          o_tx_start <= 1'b1;
          state      <= WAIT_FLG;
        end
        WAIT_FLG: begin
          if (i_tx_done) state <= GET_A;
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_interface.sv
// Bench for alu_interface: combinational ALU and 10-cycle transmitter models,
// randomized transactions, and a queue-based scoreboard on the transmit side.
module tb_alu_interface;

  localparam int NB_DATA    = 8;
  localparam int NB_OP_CODE = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  i_reset;
  logic [NB_DATA-1:0]    i_rx_data;
  logic                  i_rx_done;
  logic                  i_tx_done;
  logic [NB_DATA-1:0]    i_alu_result;
  logic                  i_alu_zero;
  logic                  i_alu_carry;
  logic [NB_DATA-1:0]    o_data_a;
  logic [NB_DATA-1:0]    o_data_b;
  logic [NB_OP_CODE-1:0] o_op_code;
  logic [NB_DATA-1:0]    o_tx_data;
  logic                  o_tx_start;
  logic                  o_busy;
  logic [2:0]            o_state;

  alu_interface #(.NB_DATA(NB_DATA), .NB_OP_CODE(NB_OP_CODE)) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_tx_done    (i_tx_done),
    .i_alu_result (i_alu_result),
    .i_alu_zero   (i_alu_zero),
    .i_alu_carry  (i_alu_carry),
    .o_data_a     (o_data_a),
    .o_data_b     (o_data_b),
    .o_op_code    (o_op_code),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .o_busy       (o_busy),
    .o_state      (o_state)
  );

  // ---------------- reference ALU: {carry, zero, result} ----------------
  function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic [8:0] sum;
    logic [7:0] res;
    logic       c;
    c = 1'b0;
    case (op)
      6'h20: begin sum = {1'b0, a} + {1'b0, b}; res = sum[7:0]; c = sum[8]; end
      6'h22: begin res = a - b; c = (a >= b); end
      6'h24: res = a & b;
      6'h25: res = a | b;
      6'h26: res = a ^ b;
      6'h27: res = ~(a | b);
      6'h03: res = 8'($signed(a) >>> b);
      6'h02: res = a >> b;
      default: res = a ^ {b[3:0], b[7:4]} ^ {2'b00, op};
    endcase
    return {c, (res == 8'h00), res};
  endfunction

  logic [9:0] alu_out;
  assign alu_out      = alu_ref(o_data_a, o_data_b, o_op_code);
  assign i_alu_result = alu_out[7:0];
  assign i_alu_zero   = alu_out[8];
  assign i_alu_carry  = alu_out[9];

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  int pend = 0;
  logic [NB_DATA-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t state=%0d)", name, act, exp, $time, o_state);
    end
  endtask

  // ---------------- transmitter model: done strobe 10 cycles after start ----------------
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      i_tx_done = 1'b0;
      if (o_tx_start) pend = 10;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) i_tx_done = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic               prev_start = 1'b0;
  logic [NB_DATA-1:0] last_tx = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_start) begin
        start_cnt++;
        check("tx_start_one_cycle", prev_start, 0);
        check("tx_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("tx_data", o_tx_data, exp_q.pop_front());
      end else if (o_tx_data !== last_tx && o_tx_data !== '0) begin
        check("tx_data_hold", o_tx_data, last_tx);
      end
      last_tx    = o_tx_data;
      prev_start = o_tx_start;
    end
  end

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && !o_busy && pend == 0) break;
      @(negedge clk);
    end
    check("idle_timeout", (k < 400), 1);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input bit extra);
    logic [5:0] op;
    logic [9:0] r;
    int s0;
    op = opb[5:0];
    r  = alu_ref(a, b, op);
    exp_q.push_back(r[7:0]);
    exp_q.push_back({6'b000000, r[9:8]});
    s0 = start_cnt;
    send_byte(a, $urandom_range(0, 2));
    check("busy_after_a", o_busy, 1);
    send_byte(b, $urandom_range(0, 2));
    send_byte(opb, 0);
    check("op_code", o_op_code, op);
    check("latency_exec", o_tx_start, 0);
    @(negedge clk);
    check("latency_send_res_reg", o_tx_start, 0);
    @(negedge clk);
    check("latency_first_start", o_tx_start, 1);
    if (extra) begin
      send_byte(8'hAA, 0);
      send_byte(8'hAA, 1);
      check("ignored_rx_a", o_data_a, a);
      check("ignored_rx_b", o_data_b, b);
      check("ignored_rx_op", o_op_code, op);
    end
    wait_idle();
    check("start_count", start_cnt - s0, 2);
    check("hold_a", o_data_a, a);
    check("hold_b", o_data_b, b);
    check("busy_idle", o_busy, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] op_tbl [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02, 6'h15};

  initial begin
    logic [5:0] op;
    logic [1:0] hi;
    i_reset   = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_a", o_data_a, 0);
    check("rst_b", o_data_b, 0);
    check("rst_op", o_op_code, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_busy", o_busy, 0);
    i_reset = 1'b0;
    @(negedge clk);

    run_txn(8'h05, 8'h03, 8'h20, 0);   // ADD -> 0x08, 0x00
    run_txn(8'h03, 8'h03, 8'h22, 0);   // SUB -> 0x00, 0x03
    run_txn(8'hFF, 8'h01, 8'h20, 0);   // ADD overflow -> 0x00, 0x03
    run_txn(8'h80, 8'h01, 8'h03, 0);   // SRA -> 0xC0, 0x00
    run_txn(8'h3C, 8'h0F, 8'hE6, 0);   // XOR with upper bits dropped
    run_txn(8'h12, 8'h34, 8'h22, 1);   // stray rx strobes during WAIT_RES

    // Abort after A and B; reset wins over a coincident rx strobe.
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    check("busy_partial", o_busy, 1);
    i_reset   = 1'b1;
    i_rx_done = 1'b1;
    i_rx_data = 8'h77;
    @(negedge clk);
    i_reset   = 1'b0;
    i_rx_done = 1'b0;
    check("abort_a", o_data_a, 0);
    check("abort_b", o_data_b, 0);
    check("abort_op", o_op_code, 0);
    check("abort_tx_data", o_tx_data, 0);
    check("abort_tx_start", o_tx_start, 0);
    check("abort_busy", o_busy, 0);
    repeat (5) @(negedge clk);
    run_txn(8'h02, 8'h02, 8'h24, 0);   // AND -> 0x02, 0x00

    for (int i = 0; i < 25; i++) begin
      op = op_tbl[$urandom_range(0, 8)];
      hi = 2'($urandom_range(0, 3));
      run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), {hi, op},
              ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_interface.md
ALU_INTERFACE -- requirements
Module: alu_interface

Interface
REQ-001 Parameter: NB_DATA, 8, width of operands, result and serial byte.
REQ-002 Parameter: NB_OP_CODE, 6, width of ALU operation code.
REQ-003 Port: i_clock  input  1  single clock; all state changes on rising edge.
REQ-004 Port: i_reset  input  1  reset, synchronous, active-high.
REQ-005 Port: i_rx_data  input  NB_DATA  byte from serial receiver.
REQ-006 Port: i_rx_done  input  1  one-cycle strobe; i_rx_data valid this cycle.
REQ-007 Port: i_tx_done  input  1  one-cycle strobe; transmitter finished current byte.
REQ-008 Port: i_alu_result  input  NB_DATA  ALU result, combinational from o_data_a/o_data_b/o_op_code.
REQ-009 Port: i_alu_zero  input  1  ALU zero flag.
REQ-010 Port: i_alu_carry  input  1  ALU carry flag (ADD carry-out; SUB no-borrow).
REQ-011 Port: o_data_a  output  NB_DATA  operand A to ALU.
REQ-012 Port: o_data_b  output  NB_DATA  operand B to ALU.
REQ-013 Port: o_op_code  output  NB_OP_CODE  operation code to ALU.
REQ-014 Port: o_tx_data  output  NB_DATA  byte to transmitter.
REQ-015 Port: o_tx_start  output  1  one-cycle strobe; transmitter loads o_tx_data.
REQ-016 Port: o_busy  output  1  high in every state except GET_A.

Function
REQ-017 FSM states SHALL be GET_A, GET_B, GET_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
REQ-018 GET_A: on i_rx_done, o_data_a <= i_rx_data, next GET_B; else hold.
REQ-019 GET_B: on i_rx_done, o_data_b <= i_rx_data, next GET_OP; else hold.
REQ-020 GET_OP: on i_rx_done, o_op_code <= i_rx_data[NB_OP_CODE-1:0] (upper bits discarded), next EXEC.
REQ-021 EXEC: exactly one cycle; result register <= i_alu_result, flag register <= {carry, zero} from i_alu_carry/i_alu_zero; next SEND_RES.
REQ-022 SEND_RES: o_tx_data <= result register, o_tx_start high exactly this one cycle; next WAIT_RES.
REQ-023 WAIT_RES: on i_tx_done, next SEND_FLG; else hold.
REQ-024 SEND_FLG: o_tx_data <= {(NB_DATA-2) zeros, carry, zero}, o_tx_start high one cycle; next WAIT_FLG.
REQ-025 WAIT_FLG: on i_tx_done, next GET_A; else hold.
REQ-026 Latency: first o_tx_start SHALL assert 2 cycles after the rising edge sampling the op-code byte's i_rx_done (EXEC, then SEND_RES).
REQ-027 i_rx_done outside GET_A/GET_B/GET_OP SHALL be ignored; no operand or op-code change.
REQ-028 i_tx_done outside WAIT_RES/WAIT_FLG SHALL be ignored.
REQ-029 o_data_a, o_data_b, o_op_code SHALL hold their values until overwritten by a new received byte; they are not cleared between transactions.
REQ-030 Op codes are not validated; unknown codes are forwarded and whatever the ALU returns is sent.
REQ-031 o_tx_data SHALL hold its last value while o_tx_start is low.
REQ-032 Back-to-back transactions SHALL be supported: a byte arriving the cycle after the WAIT_FLG→GET_A transition is accepted as A.

Reset
REQ-033 While i_reset is high at a rising edge: state <= GET_A; o_data_a, o_data_b, o_op_code, o_tx_data, result and flag registers <= 0; o_tx_start <= 0; o_busy low after the edge.
REQ-034 Reset SHALL take priority over i_rx_done and i_tx_done in the same cycle, and abort any partial transaction (no o_tx_start afterward until a full A/B/OP sequence).

Verification (bench models the ALU combinationally and the transmitter with a done strobe 10 cycles after start)
REQ-035 Rx 0x05, 0x03, 0x20 (ADD) -> o_op_code=6'b100000; tx bytes 0x08 then 0x00; o_tx_start asserted exactly twice.
REQ-036 Rx 0x03, 0x03, 0x22 (SUB) -> tx 0x00 then 0x03 (zero=1, carry=1).
REQ-037 Rx 0xFF, 0x01, 0x20 (ADD) -> tx 0x00 then 0x03; Rx 0x80, 0x01, 0x03 (SRA) -> tx 0xC0 then 0x00.
REQ-038 Rx op byte 0xE6 -> o_op_code=6'b100110 (XOR); upper two bits dropped.
REQ-039 Extra i_rx_done pulses (data 0xAA) during WAIT_RES -> o_data_a/b/op unchanged, tx sequence unaffected, next transaction starts cleanly at GET_A.
REQ-040 Reset asserted after A and B received -> all outputs 0, o_busy low; subsequent 0x02, 0x02, 0x24 (AND) -> tx 0x02 then 0x00.
